accum_drain: RTL

//  Read-side drain engine for accumCol. After a tile's accumulation finishes, it walks
//  rd_addr 0..num_rows-1 and issues one rd_en per address. It streams rd_data out on a

---
 rtl/accum_drain.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/accum_drain.sv
// -----------------------------------------------------------------------------
// accum_drain
//
// Read-side drain engine for one accumCol instance. After a tile's
// accumulation has finished, a start pulse launches a walk over read
// addresses 0..N-1. One rd_en is issued per address. The returned words are
// streamed out on a valid/ready interface in address order. out_last marks
// the final word, and done pulses for one cycle once that word has been
// accepted downstream.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; clears FSM, counters and buffer
//   start      in   begin a drain (only looked at while idle)
//   num_rows   in   number of words to drain, captured with an accepted start
//   busy       out  high from accepted start through the done cycle
//   done       out  one-cycle pulse after the final word handshakes
//   rd_en      out  read strobe to accumCol
//   rd_addr    out  read address to accumCol (0 whenever rd_en is low)
//   rd_data    in   accumCol read data, valid the cycle after rd_en
//   out_valid  out  out_data holds a word
//   out_ready  in   downstream accepts when out_valid && out_ready at posedge
//   out_data   out  drained word
//   out_last   out  qualifies the word read from address N-1
// -----------------------------------------------------------------------------
module accum_drain #(
  parameter  int DATA_WIDTH     = 8,
  parameter  int MAX_OUT_ROWS   = 128,
  parameter  int MAX_OUT_COLS   = 128,
  parameter  int SYS_ARR_COLS   = 16,
  localparam int NUM_ACCUM_ROWS = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS),
  localparam int ADDR_W         = $clog2(NUM_ACCUM_ROWS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W:0]       num_rows,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  // Counters carry one extra bit so that a full-depth drain
  // (N == NUM_ACCUM_ROWS) can be represented without wrapping.
  localparam int              CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(NUM_ACCUM_ROWS);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Registered state
  state_t                state_q,     state_d;
  logic [CNT_W-1:0]      n_q,         n_d;          // captured drain length
  logic [CNT_W-1:0]      last_idx_q,  last_idx_d;   // N-1, index of the last word
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;  // reads issued so far
  logic [CNT_W-1:0]      pop_cnt_q,   pop_cnt_d;    // words accepted downstream
  logic                  inflight_q,  inflight_d;   // rd_en of the previous cycle
  logic [1:0]            buf_cnt_q,   buf_cnt_d;    // occupancy of the 2-entry buffer
  logic [DATA_WIDTH-1:0] buf0_q,      buf0_d;       // buffer head (drives out_data)
  logic [DATA_WIDTH-1:0] buf1_q,      buf1_d;       // buffer second entry

  // Combinational helpers
  logic                  out_valid_s;
  logic                  pop_s;
  logic [2:0]            occ_s;       // buffer + inflight - pop, i.e. next occupancy
  logic [1:0]            keep_s;      // entries left in the buffer after this pop
  logic                  push0_s;
  logic                  push1_s;
  logic                  rd_en_s;
  logic [ADDR_W-1:0]     rd_addr_s;
  logic [CNT_W-1:0]      start_n_s;
  logic [CNT_W-1:0]      issue_sum_s;

  assign out_valid_s = (buf_cnt_q != 2'd0);

  // Read issue: a new read is allowed only if the buffer can still hold it
  // once the word already on rd_data lands, counting this cycle's pop.
  always_comb begin
    pop_s = out_valid_s & out_ready;
    occ_s = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    if ((state_q == S_READ) && (issue_cnt_q < n_q) && (occ_s < 3'd2)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
    if (rd_en_s) begin
      rd_addr_s = issue_cnt_q[ADDR_W-1:0];
    end else begin
      rd_addr_s = {ADDR_W{1'b0}};
    end
  end

  // Return buffer: pop shifts entry 1 into the head; the word returned for
  // last cycle's read lands in the first free slot after the pop.
  always_comb begin
    keep_s  = buf_cnt_q - {1'b0, pop_s};
    push0_s = inflight_q & (keep_s == 2'd0);
    push1_s = inflight_q & (keep_s != 2'd0);
    if (push0_s) begin
      buf0_d = rd_data;
    end else if (pop_s) begin
      buf0_d = buf1_q;
    end else begin
      buf0_d = buf0_q;
    end
    if (push1_s) begin
      buf1_d = rd_data;
    end else begin
      buf1_d = buf1_q;
    end
    buf_cnt_d  = occ_s[1:0];
    inflight_d = rd_en_s;
  end

  // Requested length, clamped to the accumulator depth.
  always_comb begin
    if (num_rows > MAX_N) begin
      start_n_s = MAX_N;
    end else begin
      start_n_s = num_rows;
    end
  end

  // FSM next state and counter updates.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    last_idx_d  = last_idx_q;
    issue_sum_s = issue_cnt_q + {{(CNT_W-1){1'b0}}, rd_en_s};
    issue_cnt_d = issue_cnt_q;
    pop_cnt_d   = pop_cnt_q + {{(CNT_W-1){1'b0}}, pop_s};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d         = start_n_s;
          last_idx_d  = start_n_s - CNT_ONE;
          issue_cnt_d = CNT_ZERO;
          pop_cnt_d   = CNT_ZERO;
          // An empty drain skips straight to the done cycle.
          if (start_n_s == CNT_ZERO) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        issue_cnt_d = issue_sum_s;
        if (issue_sum_s == n_q) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_READ;
        end
      end
      S_FLUSH: begin
        // The final word always pops here: it returns at least two cycles
        // after the last read, and READ has already been left by then.
        if (pop_s && (pop_cnt_q == last_idx_q)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; any in-flight read is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      n_q         <= CNT_ZERO;
      last_idx_q  <= CNT_ZERO;
      issue_cnt_q <= CNT_ZERO;
      pop_cnt_q   <= CNT_ZERO;
      inflight_q  <= 1'b0;
      buf_cnt_q   <= 2'd0;
      buf0_q      <= {DATA_WIDTH{1'b0}};
      buf1_q      <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      last_idx_q  <= last_idx_d;
      issue_cnt_q <= issue_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      inflight_q  <= inflight_d;
      buf_cnt_q   <= buf_cnt_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

  // rd_en must react to out_ready in the same cycle to keep one word per
  // cycle under a continuous ready, so the read strobe is not re-registered.
  assign rd_en     = rd_en_s;
  assign rd_addr   = rd_addr_s;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign out_valid = out_valid_s;
  assign out_data  = buf0_q;
  // The head is word number pop_cnt_q, so it is the last one when that
  // index equals N-1.
  assign out_last  = out_valid_s & (pop_cnt_q == last_idx_q);

endmodule
